// File: rtl/mcpu_core_stage_fetch.sv
// mcpu_core_stage_fetch: issues one icache request per translated PC and buffers the returned bundle for decode
module mcpu_core_stage_fetch (
  input  logic         clkrst_core_clk,
  input  logic         clkrst_core_rst_n,
  input  logic         ft2f_done,
  input  logic [19:0]  ft2f_out_physpage,
  input  logic [27:0]  ft2f_out_virtpc,
  output logic         ft2f_progress,
  input  logic         pipe_flush,
  output logic         f2ic_valid,
  output logic [27:0]  f2ic_paddr,
  input  logic         ic2f_ready,
  input  logic         ic2f_rvalid,
  input  logic [127:0] ic2f_packet,
  output logic         f2d_valid,
  input  logic         f2d_ready,
  output logic [127:0] f2d_packet,
  output logic [27:0]  f2d_pc
);
  typedef enum logic [1:0] {IDLE, WAIT, KILL} state_t;
  state_t state, state_nxt;
  logic buf_valid;
  logic [27:0] pend_pc;
  logic load;
  assign f2ic_paddr = {ft2f_out_physpage, ft2f_out_virtpc[7:0]};
  assign f2d_valid = buf_valid;
  assign f2ic_valid = ft2f_done & ~pipe_flush & (state == IDLE) & (~buf_valid | f2d_ready);
  assign ft2f_progress = f2ic_valid & ic2f_ready;
  assign load = (state == WAIT) & ic2f_rvalid & ~pipe_flush;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ft2f_progress ? WAIT : IDLE;
      WAIT:    state_nxt = ic2f_rvalid ? IDLE : (pipe_flush ? KILL : WAIT);
      KILL:    state_nxt = ic2f_rvalid ? IDLE : KILL;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state      <= IDLE;
      buf_valid  <= 1'b0;
      f2d_packet <= '0;
      f2d_pc     <= '0;
      pend_pc    <= '0;
    end else begin
      state     <= state_nxt;
      buf_valid <= pipe_flush ? 1'b0 : (load ? 1'b1 : (buf_valid & ~f2d_ready));
      if (load) begin
        f2d_packet <= ic2f_packet;
        f2d_pc     <= pend_pc;
      end
      if (ft2f_progress) pend_pc <= ft2f_out_virtpc;
    end
  end
endmodule

// File: tb/tb_mcpu_core_stage_fetch.sv
// tb_mcpu_core_stage_fetch: directed checks of request issue, stall, flush and reset behaviour
module tb_mcpu_core_stage_fetch;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ft2f_done = 1'b0;
  logic [19:0]  ft2f_out_physpage = '0;
  logic [27:0]  ft2f_out_virtpc = '0;
  logic         ft2f_progress;
  logic         pipe_flush = 1'b0;
  logic         f2ic_valid;
  logic [27:0]  f2ic_paddr;
  logic         ic2f_ready = 1'b0;
  logic         ic2f_rvalid = 1'b0;
  logic [127:0] ic2f_packet = '0;
  logic         f2d_valid;
  logic         f2d_ready = 1'b0;
  logic [127:0] f2d_packet;
  logic [27:0]  f2d_pc;
  int checks = 0;
  int failures = 0;
  localparam logic [127:0] P1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] P2 = {4{32'hdead_beef}};
  localparam logic [127:0] P3 = {4{32'h3333_0003}};
  localparam logic [127:0] P4 = {4{32'h4444_0004}};
  localparam logic [127:0] P5 = {4{32'h5555_0005}};
  localparam logic [127:0] P6 = {4{32'h6666_0006}};
  always #5 clk = ~clk;
  mcpu_core_stage_fetch dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst_n(rst_n),
    .ft2f_done(ft2f_done),
    .ft2f_out_physpage(ft2f_out_physpage),
    .ft2f_out_virtpc(ft2f_out_virtpc),
    .ft2f_progress(ft2f_progress),
    .pipe_flush(pipe_flush),
    .f2ic_valid(f2ic_valid),
    .f2ic_paddr(f2ic_paddr),
    .ic2f_ready(ic2f_ready),
    .ic2f_rvalid(ic2f_rvalid),
    .ic2f_packet(ic2f_packet),
    .f2d_valid(f2d_valid),
    .f2d_ready(f2d_ready),
    .f2d_packet(f2d_packet),
    .f2d_pc(f2d_pc)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_buf(input string tag, input logic v, input logic [27:0] pc, input logic [127:0] pkt);
    chk({tag, "_valid"}, f2d_valid, v);
    chk({tag, "_pc"}, f2d_pc, pc);
    chk({tag, "_packet"}, f2d_packet, pkt);
  endtask
  // issue one request with an empty buffer and return its response on the next cycle
  task automatic fetch(input logic [27:0] vpc, input logic [19:0] page, input logic [127:0] pkt);
    ft2f_done = 1'b1; ic2f_ready = 1'b1; ft2f_out_virtpc = vpc; ft2f_out_physpage = page;
    #1 chk("fetch_progress", ft2f_progress, 1'b1);
    step();
    ft2f_done = 1'b0; ic2f_rvalid = 1'b1; ic2f_packet = pkt;
    step();
    ic2f_rvalid = 1'b0;
    #1;
  endtask
  initial begin
    repeat (2) step();
    check_buf("reset", 1'b0, 28'h0, 128'h0);
    chk("reset_f2ic_valid", f2ic_valid, 1'b0);
    rst_n = 1'b1;
    step();
    ft2f_out_virtpc = 28'h0000105; ft2f_out_physpage = 20'hABCDE; ft2f_done = 1'b1; ic2f_ready = 1'b1;
    #1 chk("basic_paddr", f2ic_paddr, 28'hABCDE05);
    chk("basic_f2ic_valid", f2ic_valid, 1'b1);
    chk("basic_progress", ft2f_progress, 1'b1);
    step();
    ft2f_done = 1'b0; ic2f_rvalid = 1'b1; ic2f_packet = P1;
    #1 chk("basic_progress_pulse", ft2f_progress, 1'b0);
    chk("basic_valid_early", f2d_valid, 1'b0);
    step();
    ic2f_rvalid = 1'b0;
    #1 check_buf("basic", 1'b1, 28'h0000105, P1);
    ft2f_done = 1'b1; ft2f_out_virtpc = 28'h0000200; ft2f_out_physpage = 20'h12345;
    #1 chk("stall_f2ic_valid", f2ic_valid, 1'b0);
    chk("stall_progress", ft2f_progress, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check_buf("stall", 1'b1, 28'h0000105, P1);
      chk("stall_hold_req", f2ic_valid, 1'b0);
    end
    f2d_ready = 1'b1;
    #1 chk("drain_f2ic_valid", f2ic_valid, 1'b1);
    chk("drain_progress", ft2f_progress, 1'b1);
    step();
    ft2f_done = 1'b0; f2d_ready = 1'b0;
    #1 chk("drain_empty", f2d_valid, 1'b0);
    ic2f_rvalid = 1'b1; ic2f_packet = P2;
    step();
    ic2f_rvalid = 1'b0;
    #1 check_buf("drain_load", 1'b1, 28'h0000200, P2);
    f2d_ready = 1'b1; ft2f_done = 1'b1; ft2f_out_virtpc = 28'h0000300;
    step();
    ft2f_done = 1'b0; f2d_ready = 1'b0; pipe_flush = 1'b1;
    step();
    pipe_flush = 1'b0; ft2f_done = 1'b1; ft2f_out_virtpc = 28'h0000310;
    #1 chk("kill_no_req0", f2ic_valid, 1'b0);
    step();
    chk("kill_no_req1", f2ic_valid, 1'b0);
    step();
    ic2f_rvalid = 1'b1; ic2f_packet = P3;
    #1 chk("kill_no_req2", f2ic_valid, 1'b0);
    chk("kill_valid", f2d_valid, 1'b0);
    step();
    ic2f_rvalid = 1'b0;
    #1 chk("kill_dropped", f2d_valid, 1'b0);
    chk("kill_idle_req", ft2f_progress, 1'b1);
    step();
    ft2f_done = 1'b0; ic2f_rvalid = 1'b1; ic2f_packet = P4;
    step();
    ic2f_rvalid = 1'b0;
    #1 check_buf("after_kill", 1'b1, 28'h0000310, P4);
    pipe_flush = 1'b1; ft2f_done = 1'b1; ic2f_rvalid = 1'b1; ic2f_packet = P5;
    #1 chk("flushfull_no_req", f2ic_valid, 1'b0);
    step();
    pipe_flush = 1'b0; ic2f_rvalid = 1'b0; ft2f_done = 1'b0;
    #1 check_buf("flushfull", 1'b0, 28'h0000310, P4);
    ft2f_done = 1'b1; ft2f_out_virtpc = 28'h0000320;
    step();
    ft2f_done = 1'b0; pipe_flush = 1'b1; ic2f_rvalid = 1'b1; ic2f_packet = P5;
    #1 chk("flushresp_no_req", f2ic_valid, 1'b0);
    step();
    pipe_flush = 1'b0; ic2f_rvalid = 1'b0;
    #1 chk("flushresp_dropped", f2d_valid, 1'b0);
    ft2f_done = 1'b1;
    #1 chk("flushresp_idle", f2ic_valid, 1'b1);
    ft2f_done = 1'b0; ic2f_ready = 1'b1;
    #1 chk("notready_valid", f2ic_valid, 1'b0);
    chk("notready_progress", ft2f_progress, 1'b0);
    ic2f_ready = 1'b0;
    #1 chk("notready_progress_nordy", ft2f_progress, 1'b0);
    fetch(28'h0000500, 20'h00042, P6);
    check_buf("prereset", 1'b1, 28'h0000500, P6);
    rst_n = 1'b0;
    #1 check_buf("async_reset", 1'b0, 28'h0, 128'h0);
    step();
    rst_n = 1'b1;
    ft2f_done = 1'b1; ic2f_ready = 1'b1; ft2f_out_virtpc = 28'h0000400;
    step();
    ft2f_done = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1; ic2f_rvalid = 1'b1; ic2f_packet = P5;
    step();
    ic2f_rvalid = 1'b0;
    #1 chk("stale_valid", f2d_valid, 1'b0);
    chk("stale_pc", f2d_pc, 28'h0);
    ft2f_done = 1'b1;
    #1 chk("stale_idle", f2ic_valid, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
